// File: rtl/mem_router.sv
`default_nettype none
// ============================================================================
// Module   : mem_router
// Purpose  : Base/mask address decoder and single-outstanding bus router
//            between the CPU memory port and N_REGIONS target devices.
//            Lowest-index region wins on overlap; unmapped accesses and
//            accesses that exceed TIMEOUT cycles return resp_err_o = 1.
// Ports    : clk_i, reset_i           - clock, synchronous active-high reset
//            req_*_i / req_ready_o    - CPU request channel (valid/ready)
//            resp_*_o                 - one-cycle registered response
//            dev_valid_o / dev_ready_i / dev_rdata_i - per-target handshake
//            dev_addr/wdata/mask/rw_o - latched request, shared by targets
//            err_count_o              - saturating error-response counter
// Revision : 1.0 - initial release
// ============================================================================
module mem_router #(
    parameter int                           ADDR_W      = 64,
    parameter int                           DATA_W      = 64,
    parameter int                           N_REGIONS   = 3,
    parameter logic [N_REGIONS*ADDR_W-1:0]  REGION_BASE = '0,
    parameter logic [N_REGIONS*ADDR_W-1:0]  REGION_MASK = '0,
    parameter int                           TIMEOUT     = 15
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         req_valid_i,
    output logic                         req_ready_o,
    input  logic [ADDR_W-1:0]            req_addr_i,
    input  logic                         req_rw_i,
    input  logic [DATA_W-1:0]            req_wdata_i,
    input  logic [DATA_W/8-1:0]          req_mask_i,
    output logic                         resp_valid_o,
    output logic [DATA_W-1:0]            resp_rdata_o,
    output logic                         resp_err_o,
    output logic [N_REGIONS-1:0]         dev_valid_o,
    input  logic [N_REGIONS-1:0]         dev_ready_i,
    input  logic [N_REGIONS*DATA_W-1:0]  dev_rdata_i,
    output logic [ADDR_W-1:0]            dev_addr_o,
    output logic [DATA_W-1:0]            dev_wdata_o,
    output logic [DATA_W/8-1:0]          dev_mask_o,
    output logic                         dev_rw_o,
    output logic [7:0]                   err_count_o
);

    localparam int         SEL_W     = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1;
    localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t                  state_q;
    logic                    req_ready_q;
    logic                    resp_valid_q;
    logic [DATA_W-1:0]       resp_rdata_q;
    logic                    resp_err_q;
    logic [N_REGIONS-1:0]    dev_valid_q;
    logic [ADDR_W-1:0]       dev_addr_q;
    logic [DATA_W-1:0]       dev_wdata_q;
    logic [DATA_W/8-1:0]     dev_mask_q;
    logic                    dev_rw_q;
    logic [7:0]              err_count_q;
    logic [7:0]              timer_q;
    logic [SEL_W-1:0]        sel_q;

    // Region decode of the incoming address. Scanning from the highest index
    // down lets the lowest hitting index overwrite the others.
    logic                    hit_d;
    logic [SEL_W-1:0]        sel_d;
    logic [N_REGIONS-1:0]    onehot_d;

    always_comb begin
        hit_d = 1'b0;
        sel_d = '0;
        for (int i = N_REGIONS - 1; i >= 0; i--) begin
            if ((req_addr_i & REGION_MASK[i*ADDR_W +: ADDR_W]) ==
                REGION_BASE[i*ADDR_W +: ADDR_W]) begin
                hit_d = 1'b1;
                sel_d = SEL_W'(i);
            end
        end
        onehot_d        = '0;
        onehot_d[sel_d] = 1'b1;
    end

    // Read data of the currently selected target.
    logic [DATA_W-1:0] sel_rdata_d;
    assign sel_rdata_d = dev_rdata_i[int'(sel_q)*DATA_W +: DATA_W];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            dev_valid_q  <= '0;
            dev_addr_q   <= '0;
            dev_wdata_q  <= '0;
            dev_mask_q   <= '0;
            dev_rw_q     <= 1'b0;
            err_count_q  <= '0;
            timer_q      <= '0;
            sel_q        <= '0;
        end else begin
            resp_valid_q <= 1'b0;

            // Error responses are counted as they leave the RESP state.
            if (state_q == RESP && resp_err_q && err_count_q != 8'hFF) begin
                err_count_q <= err_count_q + 8'd1;
            end

            case (state_q)
                IDLE: begin
                    req_ready_q <= 1'b1;
                    if (req_valid_i && req_ready_q) begin
                        req_ready_q <= 1'b0;
                        dev_addr_q  <= req_addr_i;
                        dev_wdata_q <= req_wdata_i;
                        dev_mask_q  <= req_mask_i;
                        dev_rw_q    <= req_rw_i;
                        sel_q       <= sel_d;
                        timer_q     <= '0;
                        if (hit_d) begin
                            state_q     <= ACCESS;
                            dev_valid_q <= onehot_d;
                        end else begin
                            // Unmapped: answer directly, never strobe a target.
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= '0;
                        end
                    end
                end
                ACCESS: begin
                    // Completion is checked before the timeout so a ready
                    // arriving on the last allowed cycle still succeeds.
                    if (dev_ready_i[sel_q]) begin
                        state_q      <= RESP;
                        dev_valid_q  <= '0;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= dev_rw_q ? '0 : sel_rdata_d;
                    end else if (timer_q == TMO_LAST) begin
                        state_q      <= RESP;
                        dev_valid_q  <= '0;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b1;
                        resp_rdata_q <= '0;
                    end else begin
                        timer_q <= timer_q + 8'd1;
                    end
                end
                RESP: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                end
                default: begin
                    state_q     <= IDLE;
                    dev_valid_q <= '0;
                    req_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready_o  = req_ready_q;
    assign resp_valid_o = resp_valid_q;
    assign resp_rdata_o = resp_rdata_q;
    assign resp_err_o   = resp_err_q;
    assign dev_valid_o  = dev_valid_q;
    assign dev_addr_o   = dev_addr_q;
    assign dev_wdata_o  = dev_wdata_q;
    assign dev_mask_o   = dev_mask_q;
    assign dev_rw_o     = dev_rw_q;
    assign err_count_o  = err_count_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_router.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_router
// Purpose  : Directed, table-driven bench for mem_router with the BIOS/IO/RAM
//            region map, plus hand-written reset and saturation sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_router;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;
    localparam int N      = 3;
    localparam logic [N*ADDR_W-1:0] BASES = {64'h0000_0000_0000_0000,
                                             64'hFFFF_FFFF_0000_0000,
                                             64'hFFFF_FFFF_FFFF_0000};
    localparam logic [N*ADDR_W-1:0] MASKS = {64'hFFFF_FFFF_FF00_0000,
                                             64'hFFFF_FFFF_0000_0000,
                                             64'hFFFF_FFFF_FFFF_0000};
    localparam logic [63:0] RD0 = 64'hA0A0_B0B0_C0C0_D0D0;
    localparam logic [63:0] RD1 = 64'hB1B1_0101_2323_4545;
    localparam logic [63:0] RD2 = 64'h1122_3344_5566_7788;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic [63:0]       req_addr;
    logic              req_rw;
    logic [63:0]       req_wdata;
    logic [7:0]        req_mask;
    logic              resp_valid;
    logic [63:0]       resp_rdata;
    logic              resp_err;
    logic [N-1:0]      dev_valid;
    logic [N-1:0]      dev_ready;
    logic [N*64-1:0]   dev_rdata;
    logic [63:0]       dev_addr;
    logic [63:0]       dev_wdata;
    logic [7:0]        dev_mask;
    logic              dev_rw;
    logic [7:0]        err_count;

    int checks = 0;
    int errors = 0;
    int exp_errcnt = 0;

    always #5 clk = ~clk;

    mem_router #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_REGIONS(N),
        .REGION_BASE(BASES), .REGION_MASK(MASKS), .TIMEOUT(15)
    ) dut (
        .clk_i(clk), .reset_i(reset),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_addr_i(req_addr), .req_rw_i(req_rw),
        .req_wdata_i(req_wdata), .req_mask_i(req_mask),
        .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata), .resp_err_o(resp_err),
        .dev_valid_o(dev_valid), .dev_ready_i(dev_ready), .dev_rdata_i(dev_rdata),
        .dev_addr_o(dev_addr), .dev_wdata_o(dev_wdata),
        .dev_mask_o(dev_mask), .dev_rw_o(dev_rw),
        .err_count_o(err_count)
    );

    typedef struct {
        logic [63:0] addr;
        logic        rw;
        logic [63:0] wdata;
        logic [7:0]  mask;
        int          ready_at;      // edge index after acceptance; 0 = never
        logic [2:0]  other;         // ready bits held on unselected targets
        logic [2:0]  exp_dv;
        int          exp_dv_cycles;
        logic [63:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;       // cycles from acceptance to resp_valid
    } vec_t;

    vec_t vecs[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int          c;
        int          dv_cycles;
        logic [2:0]  dv_seen;
        bit          got;
        c = 0;
        while (!req_ready && c < 20) begin
            tick();
            c++;
        end
        check({nm, " ready_wait"}, 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_addr  = v.addr;
        req_rw    = v.rw;
        req_wdata = v.wdata;
        req_mask  = v.mask;
        tick();
        req_valid = 1'b0;
        dv_cycles = 0;
        dv_seen   = '0;
        got       = 1'b0;
        for (c = 0; c < 40; c++) begin
            if (resp_valid) begin
                got = 1'b1;
                break;
            end
            if (c == 0 && v.exp_dv != 3'b000) begin
                check({nm, " dev_addr"},  dev_addr, v.addr);
                check({nm, " dev_wdata"}, dev_wdata, v.wdata);
                check({nm, " dev_mask"},  64'(dev_mask), 64'(v.mask));
                check({nm, " dev_rw"},    64'(dev_rw), 64'(v.rw));
                check({nm, " ready_busy"}, 64'(req_ready), 64'd0);
            end
            dv_seen |= dev_valid;
            if (dev_valid != 3'b000) dv_cycles++;
            dev_ready = v.other | ((v.ready_at != 0 && c == v.ready_at - 1) ? v.exp_dv : 3'b000);
            tick();
        end
        dev_ready = '0;
        check({nm, " resp_seen"}, 64'(got), 64'd1);
        check({nm, " latency"},   64'(c), 64'(v.exp_lat));
        check({nm, " dev_valid"}, 64'(dv_seen), 64'(v.exp_dv));
        check({nm, " dv_cycles"}, 64'(dv_cycles), 64'(v.exp_dv_cycles));
        check({nm, " rdata"},     resp_rdata, v.exp_rdata);
        check({nm, " err"},       64'(resp_err), 64'(v.exp_err));
        if (v.exp_err && exp_errcnt < 255) exp_errcnt++;
        tick();
        check({nm, " pulse_end"}, 64'(resp_valid), 64'd0);
        check({nm, " b2b_ready"}, 64'(req_ready), 64'd1);
        check({nm, " err_count"}, 64'(err_count), 64'(exp_errcnt));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        //          addr                    rw    wdata                  mask   rdy oth     dv      dvc rdata  err lat
        vecs[0] = '{64'h0000_0000_0000_0040, 1'b0, 64'h0,                 8'hFF, 1,  3'b000, 3'b100, 1,  RD2,  1'b0, 1};
        vecs[1] = '{64'hFFFF_FFFF_FFFF_0008, 1'b0, 64'h0,                 8'hFF, 2,  3'b010, 3'b001, 2,  RD0,  1'b0, 2};
        vecs[2] = '{64'h0000_0000_0100_0000, 1'b1, 64'hDEAD_BEEF_0000_0001, 8'h0F, 0, 3'b111, 3'b000, 0, 64'h0, 1'b1, 0};
        vecs[3] = '{64'hFFFF_FFFF_0000_0010, 1'b1, 64'h0123_4567_89AB_CDEF, 8'hF0, 0, 3'b101, 3'b010, 15, 64'h0, 1'b1, 15};
        vecs[4] = '{64'hFFFF_FFFF_0000_0010, 1'b1, 64'h0123_4567_89AB_CDEF, 8'h3C, 15, 3'b000, 3'b010, 15, 64'h0, 1'b0, 15};
        vecs[5] = '{64'hFFFF_FFFF_0000_0010, 1'b0, 64'h0,                 8'hFF, 3,  3'b000, 3'b010, 3,  RD1,  1'b0, 3};
        vecs[6] = '{64'h0000_0000_00FF_FFF8, 1'b0, 64'h0,                 8'h01, 1,  3'b000, 3'b100, 1,  RD2,  1'b0, 1};

        reset     = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        req_rw    = 1'b0;
        req_wdata = '0;
        req_mask  = '0;
        dev_ready = '0;
        dev_rdata = {RD2, RD1, RD0};

        tick();
        tick();
        check("rst req_ready",  64'(req_ready), 64'd0);
        check("rst resp_valid", 64'(resp_valid), 64'd0);
        check("rst resp_rdata", resp_rdata, 64'd0);
        check("rst resp_err",   64'(resp_err), 64'd0);
        check("rst dev_valid",  64'(dev_valid), 64'd0);
        check("rst dev_addr",   dev_addr, 64'd0);
        check("rst dev_wdata",  dev_wdata, 64'd0);
        check("rst dev_mask",   64'(dev_mask), 64'd0);
        check("rst dev_rw",     64'(dev_rw), 64'd0);
        check("rst err_count",  64'(err_count), 64'd0);
        reset = 1'b0;
        tick();
        check("post_rst req_ready", 64'(req_ready), 64'd1);

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset while a target is being strobed: the access is abandoned.
        req_valid = 1'b1;
        req_addr  = 64'h0000_0000_0000_0040;
        req_rw    = 1'b0;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        check("midrst dev_valid_before", 64'(dev_valid), 64'b100);
        reset = 1'b1;
        tick();
        check("midrst dev_valid",  64'(dev_valid), 64'd0);
        check("midrst resp_valid", 64'(resp_valid), 64'd0);
        check("midrst err_count",  64'(err_count), 64'd0);
        reset = 1'b0;
        exp_errcnt = 0;
        tick();
        check("midrst req_ready", 64'(req_ready), 64'd1);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (resp_valid || dev_valid != 3'b000) seen = 1'b1;
            tick();
        end
        check("midrst no_response", 64'(seen), 64'd0);

        // Saturation of the error counter.
        for (int i = 0; i < 300; i++) begin
            run_vec(vecs[2], $sformatf("sat%0d", i));
        end
        check("sat err_count", 64'(err_count), 64'd255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
